// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Turns raw active-low board push-buttons into clean active-high
//             button bits for the memory-mapped I/O manager (address 0xFFFD).
//             Each channel has a 2-FF synchronizer, a debounce FSM with a
//             stability counter, and a one-cycle press pulse.
//  Options  : BUTTON_STICKY_EN - when defined, `buttons` presents per-channel
//             sticky press flags that are cleared by rd_ack. Otherwise
//             `buttons` is the debounced level and rd_ack is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] key_n,
    input  logic             rd_ack,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] buttons
);

    // Debounce FSM encoding
    localparam logic [1:0] c_st_released    = 2'd0;
    localparam logic [1:0] c_st_chk_press   = 2'd1;
    localparam logic [1:0] c_st_pressed     = 2'd2;
    localparam logic [1:0] c_st_chk_release = 2'd3;

    // Last counter value before a new level is accepted
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;

    // Synchronizer next-state: key_n flows through s1 then s2
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    // Synchronizer flops; reset to the released (high) level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             key_released;

        // s2 is active-low: 1 means the button is not pressed
        assign key_released = sync2_q[i];

        // Debounce decision: any bounce clears the count and returns to the
        // stable state; a full window of agreeing samples flips the level
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b0;
            case (state_q)
                c_st_released: begin
                    if (!key_released) begin
                        state_d = c_st_chk_press;
                        cnt_d   = '0;
                    end
                end
                c_st_chk_press: begin
                    if (key_released) begin
                        state_d = c_st_released;
                        cnt_d   = '0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_d = c_st_pressed;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                c_st_pressed: begin
                    if (key_released) begin
                        state_d = c_st_chk_release;
                        cnt_d   = '0;
                    end
                end
                c_st_chk_release: begin
                    if (!key_released) begin
                        state_d = c_st_pressed;
                        cnt_d   = '0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_d = c_st_released;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = c_st_released;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        // Channel state registers; reset discards any count in progress
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= c_st_released;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
            end
        end

        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;
    end

`ifdef BUTTON_STICKY_EN
    logic [N_BTN-1:0] sticky_q, sticky_d;

    // Sticky flags: a press sets, a CPU read clears; set wins on collision
    always_comb begin
        sticky_d = (sticky_q & ~{N_BTN{rd_ack}}) | btn_press;
    end

    // Sticky flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign buttons = sticky_q;
`else
    // Without sticky flags the CPU sees the live debounced level
    logic unused_rd_ack;
    assign unused_rd_ack = rd_ack;
    assign buttons       = btn_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4).
//             A run-length reference model predicts level, pulse and buttons.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [N-1:0] key_n  = '1;
    logic         rd_ack = 1'b0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] buttons;

    int total = 0;
    int bad   = 0;

    // Reference model: key delay line, per-channel run of disagreeing samples
    logic [N-1:0] m_p1, m_p2, m_level, m_press, m_sticky;
    int           m_run [N];

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .rd_ack   (rd_ack),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .buttons  (buttons)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] exp_buttons();
`ifdef BUTTON_STICKY_EN
        return m_sticky;
`else
        return m_level;
`endif
    endfunction

    task automatic model_reset();
        m_p1     = '1;
        m_p2     = '1;
        m_level  = '0;
        m_press  = '0;
        m_sticky = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    // One clock: model advances on the rising edge, ends on the falling edge
    task automatic tick();
        logic [N-1:0] samp;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            m_sticky = (m_sticky & ~{N{rd_ack}}) | m_press;
            m_press  = '0;
            samp     = ~m_p2;
            for (int i = 0; i < N; i++) begin
                if (samp[i] != m_level[i]) m_run[i]++;
                else                       m_run[i] = 0;
                if (m_run[i] == D + 1) begin
                    m_level[i] = samp[i];
                    m_press[i] = samp[i];
                    m_run[i]   = 0;
                end
            end
            m_p2 = m_p1;
            m_p1 = key_n;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        #1;
        total++;
        if ({btn_level, btn_press, buttons} !== 12'h000) begin
            bad++;
            $display("FAIL reset_async got=%h want=000", {btn_level, btn_press, buttons});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({btn_level, btn_press, buttons} !== 12'h000) begin
                bad++;
                $display("FAIL reset_hold k=%0d got=%h want=000", k, {btn_level, btn_press, buttons});
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_clean_press();
        key_n = 4'b1110;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++;
            if (btn_level !== m_level || btn_press !== m_press || buttons !== exp_buttons()) begin
                bad++;
                $display("FAIL clean_press_model k=%0d lvl=%b/%b prs=%b/%b btn=%b/%b",
                         k, btn_level, m_level, btn_press, m_press, buttons, exp_buttons());
            end
            total++;
            if (btn_level[0] !== (k >= 7) || btn_press[0] !== (k == 7) || btn_level[3:1] !== 3'b000
                || btn_press[3:1] !== 3'b000) begin
                bad++;
                $display("FAIL clean_press_timing k=%0d lvl=%b prs=%b want lvl0=%0d prs0=%0d others=0",
                         k, btn_level, btn_press, (k >= 7), (k == 7));
            end
        end
        key_n = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (btn_level !== m_level || btn_press !== m_press || buttons !== exp_buttons()) begin
                bad++;
                $display("FAIL clean_release_model k=%0d lvl=%b/%b prs=%b/%b btn=%b/%b",
                         k, btn_level, m_level, btn_press, m_press, buttons, exp_buttons());
            end
        end
    endtask

    task automatic test_bounce();
        int vals [4] = '{0, 1, 0, 1};
        int lens [4] = '{3, 1, 3, 6};
        int pulses;
        for (int p = 0; p < 4; p++) begin
            key_n[1] = vals[p][0];
            for (int k = 0; k < lens[p]; k++) begin
                tick();
                total++;
                if (btn_level !== m_level || btn_press !== m_press || buttons !== exp_buttons()) begin
                    bad++;
                    $display("FAIL bounce_model p=%0d lvl=%b/%b prs=%b/%b btn=%b/%b",
                             p, btn_level, m_level, btn_press, m_press, buttons, exp_buttons());
                end
                total++;
                if (btn_level[1] !== 1'b0 || btn_press[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce_reject p=%0d lvl1=%b prs1=%b want 0/0", p, btn_level[1], btn_press[1]);
                end
            end
        end
        pulses   = 0;
        key_n[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (btn_press[1] === 1'b1) pulses++;
            total++;
            if (btn_level !== m_level || btn_press !== m_press || buttons !== exp_buttons()) begin
                bad++;
                $display("FAIL bounce_hold_model k=%0d lvl=%b/%b prs=%b/%b btn=%b/%b",
                         k, btn_level, m_level, btn_press, m_press, buttons, exp_buttons());
            end
        end
        total++;
        if (pulses != 1 || btn_level[1] !== 1'b1) begin
            bad++;
            $display("FAIL bounce_single_pulse pulses=%0d lvl1=%b want 1/1", pulses, btn_level[1]);
        end
        key_n[1] = 1'b1;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_release();
        key_n[2] = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        total++;
        if (btn_level[2] !== 1'b1) begin
            bad++;
            $display("FAIL release_setup lvl2=%b want 1", btn_level[2]);
        end
        for (int k = 1; k <= 12; k++) begin
            key_n[2] = (k <= 2) ? 1'b1 : 1'b0;
            tick();
            total++;
            if (btn_level[2] !== 1'b1 || btn_press[2] !== 1'b0 || btn_level !== m_level) begin
                bad++;
                $display("FAIL release_glitch k=%0d lvl=%b prs2=%b want lvl2=1 prs2=0 model=%b",
                         k, btn_level, btn_press[2], m_level);
            end
        end
        key_n[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (btn_level[2] !== (k < 7) || btn_press !== 4'b0000 || buttons !== exp_buttons()) begin
                bad++;
                $display("FAIL release_timing k=%0d lvl2=%b prs=%b btn=%b want lvl2=%0d prs=0 btn=%b",
                         k, btn_level[2], btn_press, buttons, (k < 7), exp_buttons());
            end
        end
    endtask

`ifdef BUTTON_STICKY_EN
    task automatic test_sticky();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        total++;
        if (buttons !== 4'b0000) begin
            bad++;
            $display("FAIL sticky_clear_initial btn=%b want 0000", buttons);
        end
        key_n[3] = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        total++;
        if (buttons !== 4'b1000) begin
            bad++;
            $display("FAIL sticky_set btn=%b want 1000", buttons);
        end
        key_n[3] = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        total++;
        if (buttons !== 4'b1000 || btn_level[3] !== 1'b0) begin
            bad++;
            $display("FAIL sticky_persist btn=%b lvl3=%b want 1000/0", buttons, btn_level[3]);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        total++;
        if (buttons !== 4'b0000) begin
            bad++;
            $display("FAIL sticky_rd_clear btn=%b want 0000", buttons);
        end
        key_n[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            rd_ack = (k == 8) ? 1'b1 : 1'b0;
            tick();
            total++;
            if (buttons !== m_sticky || buttons[3] !== (k >= 8)) begin
                bad++;
                $display("FAIL sticky_collision k=%0d btn=%b want %b (bit3=%0d)", k, buttons, m_sticky, (k >= 8));
            end
        end
        rd_ack   = 1'b0;
        key_n[3] = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask
`else
    task automatic test_nonsticky();
        key_n[0] = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 13) key_n[0] = 1'b1;
            rd_ack = k[0];
            tick();
            total++;
            if (buttons[0] !== ((k >= 7) && (k < 19)) || buttons[3:1] !== 3'b000 || buttons !== m_level) begin
                bad++;
                $display("FAIL nonsticky_track k=%0d btn=%b want %b", k, buttons, m_level);
            end
        end
        rd_ack = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        key_n = 4'b1100;
        for (int k = 0; k < 10; k++) tick();
        total++;
        if (btn_level !== 4'b0011) begin
            bad++;
            $display("FAIL reset_mid_setup lvl=%b want 0011", btn_level);
        end
        key_n = 4'b0000;
        for (int k = 0; k < 5; k++) tick();
        #2 reset = 1'b0;
        model_reset();
        #1;
        total++;
        if ({btn_level, btn_press, buttons} !== 12'h000) begin
            bad++;
            $display("FAIL reset_mid_async got=%h want=000", {btn_level, btn_press, buttons});
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({btn_level, btn_press, buttons} !== 12'h000) begin
                bad++;
                $display("FAIL reset_mid_hold got=%h want=000", {btn_level, btn_press, buttons});
            end
        end
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (btn_press !== ((k == 7) ? 4'b1111 : 4'b0000) || btn_level !== ((k >= 7) ? 4'b1111 : 4'b0000)
                || buttons !== exp_buttons()) begin
                bad++;
                $display("FAIL reset_mid_requal k=%0d lvl=%b prs=%b btn=%b want lvl=%0d prs=%0d btn=%b",
                         k, btn_level, btn_press, buttons, (k >= 7), (k == 7), exp_buttons());
            end
        end
        key_n = 4'b1111;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(5) == 0) key_n[ch] = ~key_n[ch];
            end
            rd_ack = ($urandom_range(3) == 0);
            tick();
            total++;
            if (btn_level !== m_level || btn_press !== m_press || buttons !== exp_buttons()) begin
                bad++;
                $display("FAIL random k=%0d lvl=%b/%b prs=%b/%b btn=%b/%b",
                         k, btn_level, m_level, btn_press, m_press, buttons, exp_buttons());
            end
        end
        rd_ack = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
`ifdef BUTTON_STICKY_EN
        test_sticky();
`else
        test_nonsticky();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
